// File: rtl/fb_write_sequencer.sv
// Writes synchronised SPI pixel words into the back bank of a double-buffered
// HUB75 framebuffer and swaps banks on the display scanner's safe point.
module fb_write_sequencer #(
  parameter int BITS_PER_PIXEL = 16,
  parameter int COL_BITS       = 6,
  parameter int ROW_BITS       = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pixel_clk_in,
  input  logic [BITS_PER_PIXEL-1:0]    pixel_data_in,
  input  logic                         frame_sync,
  input  logic                         swap_ok,
  input  logic                         clear_overrun,
  output logic                         wr_en,
  output logic [COL_BITS+ROW_BITS-1:0] wr_addr,
  output logic [BITS_PER_PIXEL-1:0]    wr_data,
  output logic                         wr_bank,
  output logic                         disp_bank,
  output logic                         frame_done,
  output logic                         overrun
);

  localparam int AW = COL_BITS + ROW_BITS;
  localparam logic [AW-1:0] LAST = '1;

  typedef enum logic {
    FILL,
    WAIT_SWAP
  } state_t;

  state_t          state, state_n;
  logic            sync1, sync2, hist;
  logic            pix_edge;
  logic [AW-1:0]   cnt, cnt_n, addr_n;
  logic            we_n, bank_n, done_n, ovr_set;

  // Receiver idles with the strobe high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= 1'b1;
    end else begin
      sync1 <= pixel_clk_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign pix_edge  = sync2 & ~hist;
  assign disp_bank = ~wr_bank;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FILL;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = wr_addr;
    we_n    = 1'b0;
    bank_n  = wr_bank;
    done_n  = 1'b0;
    ovr_set = 1'b0;
    if (frame_sync) begin
      // Restart in the current bank; a same-cycle pixel becomes pixel 0.
      state_n = FILL;
      cnt_n   = '0;
      if (pix_edge) begin
        we_n   = 1'b1;
        addr_n = '0;
        cnt_n  = AW'(1);
      end
    end else begin
      case (state)
        FILL: begin
          if (pix_edge) begin
            we_n   = 1'b1;
            addr_n = cnt;
            cnt_n  = cnt + AW'(1);
            if (cnt == LAST) state_n = WAIT_SWAP;
          end
        end
        WAIT_SWAP: begin
          if (swap_ok) begin
            state_n = FILL;
            bank_n  = ~wr_bank;
            done_n  = 1'b1;
            cnt_n   = '0;
            if (pix_edge) begin
              we_n   = 1'b1;
              addr_n = '0;
              cnt_n  = AW'(1);
            end
          end else if (pix_edge) begin
            ovr_set = 1'b1;
          end
        end
        default: state_n = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_bank    <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      wr_en      <= we_n;
      wr_addr    <= addr_n;
      wr_bank    <= bank_n;
      frame_done <= done_n;
      if (pix_edge) wr_data <= pixel_data_in;
      if (ovr_set)            overrun <= 1'b1;
      else if (clear_overrun) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fb_write_sequencer.sv
// Directed bench for fb_write_sequencer on a 4x2 (8-pixel) framebuffer.
// Pixels are strobed like the SPI receiver would, writes observed on negedge.
module tb_fb_write_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        pixel_clk_in;
  logic [15:0] pixel_data_in;
  logic        frame_sync;
  logic        swap_ok;
  logic        clear_overrun;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_bank;
  logic        disp_bank;
  logic        frame_done;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic prev_we = 1'b0;

  fb_write_sequencer #(
    .BITS_PER_PIXEL(16),
    .COL_BITS(2),
    .ROW_BITS(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pixel_clk_in(pixel_clk_in),
    .pixel_data_in(pixel_data_in),
    .frame_sync(frame_sync),
    .swap_ok(swap_ok),
    .clear_overrun(clear_overrun),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_bank(wr_bank),
    .disp_bank(disp_bank),
    .frame_done(frame_done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (wr_en) chk("wr_en_gap", {31'b0, prev_we}, 0);
    prev_we = wr_en;
  end

  // side: 0 none, 1 swap_ok, 2 frame_sync, 3 clear_overrun in the edge cycle
  task automatic pixel(input logic [15:0] d, input bit exp_wr,
                       input logic [2:0] exp_addr, input logic exp_bank,
                       input int side);
    int t0;
    bit seen;
    @(posedge clk); #1;
    pixel_data_in = d;
    pixel_clk_in  = 1'b0;
    repeat (3) @(posedge clk);
    #1 pixel_clk_in = 1'b1;
    t0 = cyc;
    seen = 0;
    if (side != 0) begin
      repeat (2) @(posedge clk);
      #1;
      swap_ok       = (side == 1);
      frame_sync    = (side == 2);
      clear_overrun = (side == 3);
      @(posedge clk); #1;
      swap_ok       = 1'b0;
      frame_sync    = 1'b0;
      clear_overrun = 1'b0;
    end
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (wr_en) begin
        seen = 1;
        if (exp_wr) begin
          chk("latency", cyc - t0, 3);
          chk("wr_addr", {29'b0, wr_addr}, {29'b0, exp_addr});
          chk("wr_data", {16'b0, wr_data}, {16'b0, d});
          chk("wr_bank", {31'b0, wr_bank}, {31'b0, exp_bank});
        end
      end
    end
    chk(exp_wr ? "write_seen" : "drop_no_write", {31'b0, seen},
        {31'b0, exp_wr});
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_swap(input logic exp_bank);
    int d0;
    d0 = done_cnt;
    @(posedge clk); #1 swap_ok = 1'b1;
    @(posedge clk); #1 swap_ok = 1'b0;
    @(negedge clk);
    chk("swap_done", {31'b0, frame_done}, 1);
    chk("swap_wr_bank", {31'b0, wr_bank}, {31'b0, exp_bank});
    chk("swap_disp_bank", {31'b0, disp_bank}, {31'b0, ~exp_bank});
    @(negedge clk);
    chk("swap_done_once", done_cnt - d0, 1);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear_overrun = 1'b1;
    @(posedge clk); #1 clear_overrun = 1'b0;
    @(negedge clk);
    chk("overrun_cleared", {31'b0, overrun}, 0);
  endtask

  initial begin
    int we_cnt;
    reset         = 1'b1;
    pixel_clk_in  = 1'b1;
    pixel_data_in = 16'h0;
    frame_sync    = 1'b0;
    swap_ok       = 1'b0;
    clear_overrun = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", {31'b0, wr_en}, 0);
    chk("rst_wr_addr", {29'b0, wr_addr}, 0);
    chk("rst_wr_data", {16'b0, wr_data}, 0);
    chk("rst_wr_bank", {31'b0, wr_bank}, 0);
    chk("rst_disp_bank", {31'b0, disp_bank}, 1);
    chk("rst_frame_done", {31'b0, frame_done}, 0);
    chk("rst_overrun", {31'b0, overrun}, 0);
    @(posedge clk); #1 reset = 1'b0;

    we_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (wr_en) we_cnt++;
    end
    chk("idle_no_write", we_cnt, 0);

    for (int i = 0; i < 8; i++)
      pixel(16'h1000 + 16'(i), 1, 3'(i), 1'b0, 0);
    chk("fill_no_done", done_cnt, 0);

    pixel(16'hBEEF, 0, 3'd0, 1'b0, 0);
    chk("overrun_set", {31'b0, overrun}, 1);
    chk("drop_no_done", done_cnt, 0);

    pulse_swap(1'b1);
    for (int i = 0; i < 8; i++)
      pixel(16'h2000 + 16'(i), 1, 3'(i), 1'b1, 0);

    pulse_clear();
    pixel(16'hDEAD, 0, 3'd0, 1'b1, 3);
    chk("set_beats_clear", {31'b0, overrun}, 1);
    pulse_clear();

    pixel(16'h3000, 1, 3'd0, 1'b0, 1);
    chk("coinc_overrun", {31'b0, overrun}, 0);
    chk("coinc_done", done_cnt, 2);
    chk("coinc_disp_bank", {31'b0, disp_bank}, 1);

    for (int i = 1; i < 5; i++)
      pixel(16'h3000 + 16'(i), 1, 3'(i), 1'b0, 0);
    @(posedge clk); #1 frame_sync = 1'b1;
    @(posedge clk); #1 frame_sync = 1'b0;
    for (int i = 0; i < 8; i++)
      pixel(16'h4000 + 16'(i), 1, 3'(i), 1'b0, 0);
    chk("sync_no_done", done_cnt, 2);
    pixel(16'h4BAD, 0, 3'd0, 1'b0, 0);
    chk("sync_frame_full", {31'b0, overrun}, 1);
    pulse_swap(1'b1);

    for (int i = 0; i < 3; i++)
      pixel(16'h5000 + 16'(i), 1, 3'(i), 1'b1, 0);
    @(negedge clk); #2 reset = 1'b1;
    #1;
    chk("mid_rst_wr_addr", {29'b0, wr_addr}, 0);
    chk("mid_rst_wr_data", {16'b0, wr_data}, 0);
    chk("mid_rst_wr_bank", {31'b0, wr_bank}, 0);
    chk("mid_rst_disp_bank", {31'b0, disp_bank}, 1);
    chk("mid_rst_overrun", {31'b0, overrun}, 0);
    chk("mid_rst_wr_en", {31'b0, wr_en}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    pixel(16'h6000, 1, 3'd0, 1'b0, 0);
    pixel(16'h6001, 1, 3'd1, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got %0d exp done", cyc);
    $fatal(1, "timeout");
  end

endmodule
